// File: rtl/galvo_point_sequencer.sv
// Point FIFO plus DAC frame sequencer that drives an SPI master for a two-channel galvo DAC.
// Optional build macro GALVO_BLANK_ON_UNDERFLOW_EN: an underflow tick also blanks the laser.
module galvo_point_sequencer #(
    parameter int DEPTH       = 16,
    parameter int CLK_DIV     = 4,
    parameter int LDAC_CYCLES = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_wr_en,
    input  logic [31:0]            i_wr_data,
    input  logic [15:0]            i_period,
    input  logic                   i_run,
    input  logic                   i_clear,
    input  logic                   i_spi_done,
    output logic                   o_spi_start,
    output logic [31:0]            o_spi_ctrl,
    output logic [31:0]            o_spi_din,
    output logic                   o_cs_n,
    output logic                   o_ldac_n,
    output logic                   o_laser_on,
    output logic [$clog2(DEPTH):0] o_fifo_count,
    output logic                   o_fifo_full,
    output logic                   o_busy,
    output logic                   o_underflow,
    output logic                   o_overflow,
    output logic                   o_late
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(LDAC_CYCLES + 2);

`ifdef GALVO_BLANK_ON_UNDERFLOW_EN
    localparam bit BLANK_ON_UNDERFLOW = 1'b1;
`else
    localparam bit BLANK_ON_UNDERFLOW = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_X, S_WBUSY_X, S_WDONE_X, S_GAP,
        S_LOAD_Y, S_WBUSY_Y, S_WDONE_Y, S_LATCH
    } state_t;

    state_t          r_state, w_state_next;
    logic [24:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [15:0]     r_period_cnt;
    logic            r_pending;
    logic [LW-1:0]   r_cnt, w_cnt_next;
    logic [11:0]     r_point_y;
    logic            r_point_laser;
    logic            r_cs_n, r_ldac_n, r_laser_on, r_spi_start;
    logic [15:0]     r_spi_din;
    logic            r_underflow, r_overflow, r_late;

    logic            w_cs_n_next, w_ldac_n_next, w_laser_next, w_start_next;
    logic [15:0]     w_din_next;
    logic            w_pop, w_consume, w_underflow_set;
    logic            w_full, w_empty, w_push, w_tick, w_late_set;
    logic [24:0]     w_rd_data;
    logic [15:0]     w_period_last;
    logic            w_unused_wr_bits;

    assign w_unused_wr_bits = &{1'b0, i_wr_data[31:25]};
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = i_wr_en && !w_full;
    assign w_rd_data = r_mem[r_rd_ptr];

    // A period of 0 behaves like 1, i.e. a tick on every running cycle.
    assign w_period_last = (i_period == 16'd0) ? 16'd0 : i_period - 16'd1;
    assign w_tick        = i_run && (r_period_cnt >= w_period_last);
    assign w_late_set    = w_tick && r_pending && !w_consume;

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data[24:0];
    end

    always_comb begin
        w_state_next    = r_state;
        w_cs_n_next     = r_cs_n;
        w_ldac_n_next   = r_ldac_n;
        w_laser_next    = r_laser_on;
        w_start_next    = 1'b0;
        w_din_next      = r_spi_din;
        w_cnt_next      = r_cnt;
        w_pop           = 1'b0;
        w_consume       = 1'b0;
        w_underflow_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending && i_run) begin
                    w_consume = 1'b1;
                    if (w_empty) begin
                        w_underflow_set = 1'b1;
                        if (BLANK_ON_UNDERFLOW) w_laser_next = 1'b0;
                    end else begin
                        w_pop        = 1'b1;
                        w_start_next = 1'b1;
                        w_cs_n_next  = 1'b0;
                        w_din_next   = {4'h3, w_rd_data[23:12]};
                        w_state_next = S_LOAD_X;
                    end
                end
            end
            S_LOAD_X:  w_state_next = S_WBUSY_X;
            S_WBUSY_X: if (!i_spi_done) w_state_next = S_WDONE_X;
            S_WDONE_X: begin
                if (i_spi_done) begin
                    w_cs_n_next  = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_cnt_next = LW'(1);
                end else begin
                    w_cnt_next   = '0;
                    w_start_next = 1'b1;
                    w_cs_n_next  = 1'b0;
                    w_din_next   = {4'hB, r_point_y};
                    w_state_next = S_LOAD_Y;
                end
            end
            S_LOAD_Y:  w_state_next = S_WBUSY_Y;
            S_WBUSY_Y: if (!i_spi_done) w_state_next = S_WDONE_Y;
            S_WDONE_Y: begin
                // ldac_n is only lowered from the second LATCH cycle so it trails the cs_n rise.
                if (i_spi_done) begin
                    w_cs_n_next  = 1'b1;
                    w_laser_next = r_point_laser;
                    w_cnt_next   = '0;
                    w_state_next = S_LATCH;
                end
            end
            S_LATCH: begin
                if (r_cnt == '0) begin
                    w_ldac_n_next = 1'b0;
                    w_cnt_next    = LW'(1);
                end else if (r_cnt == LW'(LDAC_CYCLES)) begin
                    w_ldac_n_next = 1'b1;
                    w_cnt_next    = '0;
                    w_state_next  = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + LW'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_period_cnt  <= '0;
            r_pending     <= 1'b0;
            r_cnt         <= '0;
            r_point_y     <= '0;
            r_point_laser <= 1'b0;
            r_cs_n        <= 1'b1;
            r_ldac_n      <= 1'b1;
            r_laser_on    <= 1'b0;
            r_spi_start   <= 1'b0;
            r_spi_din     <= '0;
            r_underflow   <= 1'b0;
            r_overflow    <= 1'b0;
            r_late        <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_cs_n      <= w_cs_n_next;
            r_ldac_n    <= w_ldac_n_next;
            r_laser_on  <= w_laser_next;
            r_spi_start <= w_start_next;
            r_spi_din   <= w_din_next;

            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) begin
                r_rd_ptr      <= r_rd_ptr + AW'(1);
                r_point_y     <= w_rd_data[11:0];
                r_point_laser <= w_rd_data[24];
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);

            if (!i_run || w_tick) r_period_cnt <= '0;
            else                  r_period_cnt <= r_period_cnt + 16'd1;

            // A tick landing on the consuming cycle refills the slot instead of counting as late.
            if (!i_run)         r_pending <= 1'b0;
            else if (w_tick)    r_pending <= 1'b1;
            else if (w_consume) r_pending <= 1'b0;

            if (w_underflow_set)          r_underflow <= 1'b1;
            else if (i_clear)             r_underflow <= 1'b0;
            if (i_wr_en && w_full)        r_overflow  <= 1'b1;
            else if (i_clear)             r_overflow  <= 1'b0;
            if (w_late_set)               r_late      <= 1'b1;
            else if (i_clear)             r_late      <= 1'b0;
        end
    end

    assign o_spi_start  = r_spi_start;
    assign o_spi_ctrl   = {16'd0, 8'(CLK_DIV), 8'd16};
    assign o_spi_din    = {16'd0, r_spi_din};
    assign o_cs_n       = r_cs_n;
    assign o_ldac_n     = r_ldac_n;
    assign o_laser_on   = r_laser_on;
    assign o_fifo_count = r_count;
    assign o_fifo_full  = w_full;
    assign o_busy       = (r_state != S_IDLE);
    assign o_underflow  = r_underflow;
    assign o_overflow   = r_overflow;
    assign o_late       = r_late;
endmodule

// File: doc/galvo_point_sequencer.md
# galvo_point_sequencer

Point sequencer for the laser projector: buffers X/Y/laser points written by the Beta, and on each point-period tick drives the two-channel galvo DAC (MCP4922-style, 16-bit frames) through the SPI master. Sits directly upstream of the SPI master. It drives the master's `start`/`ctrl_reg`/`din` and consumes `status_reg[0]` as the done flag. It also owns DAC chip-select, LDAC and the laser gate.

## Interface
- `DEPTH`, 16: point FIFO depth (power of two, ≥2).
- `CLK_DIV`, 4: SPI clock divider placed in `spi_ctrl[15:8]` (1–255).
- `LDAC_CYCLES`, 2: width of the `ldac_n` low pulse, in clk cycles (≥1).
- `clk`  in  1  system clock; only clock.
- `reset`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  push `wr_data` into FIFO.
- `wr_data`  in  32  `[24]` laser, `[23:12]` X, `[11:0]` Y; `[31:25]` ignored.
- `period`  in  16  point period in clk cycles; 0 treated as 1.
- `run`  in  1  enable point output.
- `clear`  in  1  one-cycle pulse; clears sticky flags.
- `spi_done`  in  1  SPI master `status_reg[0]`.
- `spi_start`  out  1  one-cycle start pulse to SPI master.
- `spi_ctrl`  out  32  constant `{16'd0, CLK_DIV[7:0], 8'd16}`.
- `spi_din`  out  32  `{16'd0, frame[15:0]}`; bit 15 is sent first.
- `cs_n`  out  1  DAC chip select.
- `ldac_n`  out  1  DAC latch strobe.
- `laser_on`  out  1  laser gate.
- `fifo_count`  out  clog2(DEPTH)+1  current occupancy.
- `fifo_full`  out  1  count == DEPTH.
- `busy`  out  1  FSM not in IDLE.
- `underflow`, `overflow`, `late`  out  1 each  sticky flags.

## Operation
- FIFO:
  - A write while full is dropped and sets `overflow`. This holds even if a pop occurs in the same cycle.
  - A write and a pop in the same cycle when not full leave the count unchanged.
- Period counter:
  - Free-runs whenever `run`=1 and is held at 0 while `run`=0.
  - Emits `tick` on the cycle it reaches `period`-1, then wraps to 0.
- Pending tick:
  - A `tick` sets a one-deep `pending` flag.
  - A `tick` while `pending` is already set sets `late`; the tick is not queued.
- FSM states: IDLE, LOAD_X, WBUSY_X, WDONE_X, GAP, LOAD_Y, WBUSY_Y, WDONE_Y, LATCH.
  - IDLE, `pending` set, FIFO non-empty: pop the point, clear `pending`, go to LOAD_X.
  - IDLE, `pending` set, FIFO empty: clear `pending`, set `underflow`, hold the DAC; no SPI traffic.
  - LOAD_X: `cs_n`←0, `spi_din`←`16'h3000|X`, `spi_start`=1 for one cycle → WBUSY_X.
  - WBUSY_X: wait for `spi_done`=0 → WDONE_X.
  - WDONE_X: wait for `spi_done`=1, then `cs_n`←1 → GAP.
  - GAP: 2 cycles with `cs_n` high → LOAD_Y.
  - LOAD_Y / WBUSY_Y / WDONE_Y: same sequence with `16'hB000|Y`.
  - LATCH: `ldac_n` low for `LDAC_CYCLES`. `laser_on` is updated to the point's laser bit on the first LATCH cycle → IDLE.
- `run` deassert mid-point: the current point completes; no new pops. FIFO contents are retained.
- `clear` and a flag-setting event in the same cycle: the set wins.

## Timing
- Reset values:
  - `cs_n`=1, `ldac_n`=1, `laser_on`=0, `spi_start`=0, `spi_din`=0.
  - All flags=0, FIFO empty, FSM=IDLE, counter=0, `pending`=0.
- Reset mid-point: the FSM returns to IDLE and `cs_n` rises immediately (the DAC discards the partial frame). Any later `spi_done` transitions from the un-reset SPI master are ignored in IDLE.
- Tick to `spi_start`: 2 cycles (tick → pending reg → IDLE pop → LOAD_X pulse).
- The SPI master drops `spi_done` 2 cycles after `start`. WBUSY must not time out.
- LOAD cycles register all outputs; no combinational path from `spi_done` to any output.
- `ldac_n` falls no earlier than 1 cycle after `cs_n` rises for the Y frame.
- Minimum useful `period` ≈ 2×(16×2×(CLK_DIV+1)+6)+LDAC_CYCLES+6 cycles; shorter periods set `late`.

## Configuration
- `GALVO_BLANK_ON_UNDERFLOW_EN`:
  - Defined: an underflow tick also forces `laser_on`←0 (blank while starved). The DAC position is held.
  - Undefined: `laser_on` keeps its last value on underflow.

## Test plan
- Reset, write `0x01ABC123`, `period`=400, `run`=1, with an SPI model → `spi_din`=`0x3ABC` then `0xB123`. `cs_n` goes low twice with a ≥2-cycle high gap. `ldac_n` is low 2 cycles. `laser_on`=1 from the first LATCH cycle.
- FIFO empty, `run`=1 → `underflow`=1 after the first tick; no `spi_start`. `laser_on` goes 0 only with `GALVO_BLANK_ON_UNDERFLOW_EN` defined.
- 17 writes with DEPTH=16, `run`=0 → `fifo_count`=16, `fifo_full`=1, `overflow`=1. The 17th data word never appears on `spi_din`.
- `period`=20 (shorter than a transfer) → `late`=1. Each point still completes X, Y, then LATCH in order. `clear` pulse returns `late` to 0.
- Assert `reset` while in WDONE_X → next cycle `cs_n`=1, `busy`=0, FIFO empty. A subsequent `spi_done` rise causes no `ldac_n` pulse.
- `run` dropped during WBUSY_Y → the point finishes with LATCH. No further pops; `fifo_count` is unchanged afterwards.
